// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU operation at a time and drives the latched
// opcode and operands to an external ALU for a per-opcode number of cycles.
// It then captures the ALU result and holds it until the consumer takes it.
// A DIV by zero and an illegal opcode do not present an operation to the ALU.
// Each of them spends a single silent cycle in EXEC with the ALU outputs held
// at 0, so that its result appears with the same latency as a one-cycle
// operation.
module alu_sequencer #(
  parameter int MUL_CYCLES = 16,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_ra,
  input  logic [31:0] req_rb,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_ra,
  output logic [31:0] alu_rb,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        err_div0,
  output logic        err_illegal,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] OP_FIRST = 5'b00011;
  localparam logic [4:0] OP_LAST  = 5'b10010;
  localparam logic [4:0] OP_DIV   = 5'b01111;
  localparam logic [4:0] OP_MUL   = 5'b10000;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  // Legal opcodes form one contiguous range, ADD through NOT.
  function automatic logic op_is_legal(input logic [4:0] op);
    return (op >= OP_FIRST) && (op <= OP_LAST);
  endfunction

  // Counter load value (N-1) for a legal opcode.
  function automatic logic [5:0] count_load(input logic [4:0] op);
    logic [5:0] load;
    case (op)
      OP_MUL:  load = MUL_LOAD;
      OP_DIV:  load = DIV_LOAD;
      default: load = 6'd0;
    endcase
    return load;
  endfunction

  logic [1:0]  state_r, state_s;
  logic [5:0]  count_r, count_s;
  logic [4:0]  alu_op_r, alu_op_s;
  logic [31:0] alu_ra_r, alu_ra_s;
  logic [31:0] alu_rb_r, alu_rb_s;
  logic        pend_div0_r, pend_div0_s;
  logic        pend_ill_r, pend_ill_s;
  logic        res_valid_r, res_valid_s;
  logic [31:0] res_hi_r, res_hi_s;
  logic [31:0] res_lo_r, res_lo_s;
  logic        err_div0_r, err_div0_s;
  logic        err_ill_r, err_ill_s;
  logic        req_ready_r, req_ready_s;
  logic        busy_r, busy_s;

  // Next-state and next-output computation for the three-state sequencer.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    alu_op_s    = alu_op_r;
    alu_ra_s    = alu_ra_r;
    alu_rb_s    = alu_rb_r;
    pend_div0_s = pend_div0_r;
    pend_ill_s  = pend_ill_r;
    res_valid_s = res_valid_r;
    res_hi_s    = res_hi_r;
    res_lo_s    = res_lo_r;
    err_div0_s  = err_div0_r;
    err_ill_s   = err_ill_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          state_s = S_EXEC;
          if (!op_is_legal(req_op)) begin
            count_s    = 6'd0;
            pend_ill_s = 1'b1;
          end else if ((req_op == OP_DIV) && (req_rb == 32'd0)) begin
            count_s     = 6'd0;
            pend_div0_s = 1'b1;
          end else begin
            count_s  = count_load(req_op);
            alu_op_s = req_op;
            alu_ra_s = req_ra;
            alu_rb_s = req_rb;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_EXEC: begin
        if (count_r == 6'd0) begin
          state_s     = S_DONE;
          res_valid_s = 1'b1;
          if (pend_div0_r || pend_ill_r) begin
            res_hi_s = 32'd0;
            res_lo_s = 32'd0;
          end else begin
            res_hi_s = alu_hi;
            res_lo_s = alu_lo;
          end
          err_div0_s  = pend_div0_r;
          err_ill_s   = pend_ill_r;
          pend_div0_s = 1'b0;
          pend_ill_s  = 1'b0;
          alu_op_s    = 5'd0;
          alu_ra_s    = 32'd0;
          alu_rb_s    = 32'd0;
        end else begin
          count_s = count_r - 6'd1;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_s     = S_IDLE;
          res_valid_s = 1'b0;
          err_div0_s  = 1'b0;
          err_ill_s   = 1'b0;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s     = S_IDLE;
        count_s     = 6'd0;
        alu_op_s    = 5'd0;
        alu_ra_s    = 32'd0;
        alu_rb_s    = 32'd0;
        pend_div0_s = 1'b0;
        pend_ill_s  = 1'b0;
        res_valid_s = 1'b0;
        err_div0_s  = 1'b0;
        err_ill_s   = 1'b0;
      end
    endcase
    req_ready_s = (state_s == S_IDLE);
    busy_s      = (state_s != S_IDLE);
  end

  // State and output registers; clear has priority over any handshake.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r     <= S_IDLE;
      count_r     <= 6'd0;
      alu_op_r    <= 5'd0;
      alu_ra_r    <= 32'd0;
      alu_rb_r    <= 32'd0;
      pend_div0_r <= 1'b0;
      pend_ill_r  <= 1'b0;
      res_valid_r <= 1'b0;
      res_hi_r    <= 32'd0;
      res_lo_r    <= 32'd0;
      err_div0_r  <= 1'b0;
      err_ill_r   <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      alu_op_r    <= alu_op_s;
      alu_ra_r    <= alu_ra_s;
      alu_rb_r    <= alu_rb_s;
      pend_div0_r <= pend_div0_s;
      pend_ill_r  <= pend_ill_s;
      res_valid_r <= res_valid_s;
      res_hi_r    <= res_hi_s;
      res_lo_r    <= res_lo_s;
      err_div0_r  <= err_div0_s;
      err_ill_r   <= err_ill_s;
      req_ready_r <= req_ready_s;
      busy_r      <= busy_s;
    end
  end

  assign req_ready   = req_ready_r;
  assign busy        = busy_r;
  assign alu_op      = alu_op_r;
  assign alu_ra      = alu_ra_r;
  assign alu_rb      = alu_rb_r;
  assign res_valid   = res_valid_r;
  assign res_hi      = res_hi_r;
  assign res_lo      = res_lo_r;
  assign err_div0    = err_div0_r;
  assign err_illegal = err_ill_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural ALU answers the DUT's ALU port.
// Each transaction's latency, ALU drive and result are predicted from the
// opcode and operands alone.
module tb_alu_sequencer;

  localparam int MULC = 16;
  localparam int DIVC = 32;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_ra, req_rb;
  logic [4:0]  alu_op;
  logic [31:0] alu_ra, alu_rb;
  logic [31:0] alu_hi, alu_lo;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_hi, res_lo;
  logic        err_div0, err_illegal, busy;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  alu_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_ra(req_ra), .req_rb(req_rb),
    .alu_op(alu_op), .alu_ra(alu_ra), .alu_rb(alu_rb),
    .alu_hi(alu_hi), .alu_lo(alu_lo),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo),
    .err_div0(err_div0), .err_illegal(err_illegal), .busy(busy)
  );

  // Behavioural ALU: returns {hi, lo}.
  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] t;
    logic [4:0]  s;
    s = b[4:0];
    t = 64'd0;
    case (op)
      5'd3:  t[31:0] = a + b;
      5'd4:  t[31:0] = a - b;
      5'd5:  t[31:0] = a & b;
      5'd6:  t[31:0] = a | b;
      5'd7:  begin t = {a, a} >> s; t[63:32] = 32'd0; end
      5'd8:  begin t = {a, a} << s; t = {32'd0, t[63:32]}; end
      5'd9:  t[31:0] = a >> s;
      5'd10: t[31:0] = $signed(a) >>> s;
      5'd11: t[31:0] = a << s;
      5'd12: t[31:0] = a + b;
      5'd13: t[31:0] = a & b;
      5'd14: t[31:0] = a | b;
      5'd15: if (b != 32'd0) t = {a % b, a / b};
      5'd16: t = {32'd0, a} * {32'd0, b};
      5'd17: t[31:0] = 32'd0 - a;
      5'd18: t[31:0] = ~a;
      default: t = 64'd0;
    endcase
    return t;
  endfunction

  always_comb {alu_hi, alu_lo} = alu_fn(alu_op, alu_ra, alu_rb);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_req();
    req_valid = 1'($urandom_range(0, 1));
    req_op    = 5'($urandom);
    req_ra    = $urandom;
    req_rb    = $urandom;
  endtask

  // One transaction starting at a negedge with the DUT idle; the consumer
  // stalls for 'hold' cycles in DONE. Ends at the negedge after the handoff.
  task automatic run_op(input logic [4:0] op, input logic [31:0] ra, input logic [31:0] rb, input int hold);
    logic        illegal, div0;
    int          n;
    logic [63:0] exp_res;
    illegal = !((op >= 5'd3) && (op <= 5'd18));
    div0    = (op == 5'd15) && (rb == 32'd0);
    if (illegal || div0) n = 1;
    else if (op == 5'd16) n = MULC;
    else if (op == 5'd15) n = DIVC;
    else n = 1;
    exp_res = (illegal || div0) ? 64'd0 : alu_fn(op, ra, rb);

    check("idle_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_ra = ra; req_rb = rb;
    res_ready = 1'($urandom_range(0, 1));
    @(negedge clock);
    for (int k = 0; k < n; k++) begin
      check("exec_valid", res_valid, 1'b0);
      check("exec_ready", req_ready, 1'b0);
      check("exec_busy", busy, 1'b1);
      check("exec_alu_op", alu_op, (illegal || div0) ? 5'd0 : op);
      check("exec_alu_ra", alu_ra, (illegal || div0) ? 32'd0 : ra);
      check("exec_alu_rb", alu_rb, (illegal || div0) ? 32'd0 : rb);
      scramble_req();
      res_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    for (int h = 0; h <= hold; h++) begin
      check("done_valid", res_valid, 1'b1);
      check("done_ready", req_ready, 1'b0);
      check("done_hi", res_hi, exp_res[63:32]);
      check("done_lo", res_lo, exp_res[31:0]);
      check("done_div0", err_div0, div0);
      check("done_ill", err_illegal, illegal);
      check("done_alu_op", alu_op, 5'd0);
      scramble_req();
      if (h < hold) res_ready = 1'b0;
      else begin res_ready = 1'b1; req_valid = 1'b0; end
      @(negedge clock);
    end
    res_ready = 1'b0;
    check("post_ready", req_ready, 1'b1);
    check("post_busy", busy, 1'b0);
    check("post_valid", res_valid, 1'b0);
    check("post_errs", {err_div0, err_illegal}, 2'b00);
    check("post_hi", res_hi, exp_res[63:32]);
    check("post_lo", res_lo, exp_res[31:0]);
  endtask

  logic [4:0] legal_ops [16] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18};

  initial begin
    logic [4:0]  op;
    logic [31:0] ra, rb;
    clear = 1'b0; req_valid = 1'b0; req_op = 5'd0; req_ra = 32'd0; req_rb = 32'd0;
    res_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", req_ready, 1'b1);
    check("rst_outs", {busy, res_valid, err_div0, err_illegal, alu_op}, 9'd0);
    check("rst_res", {res_hi, res_lo}, 64'd0);
    check("rst_alu", {alu_ra, alu_rb}, 64'd0);
    clear = 1'b1;

    run_op(5'b00011, 32'd5, 32'd7, 0);
    run_op(5'b10000, $urandom, $urandom, 2);
    run_op(5'b01111, $urandom, 32'd0, 1);
    run_op(5'b11111, $urandom, $urandom, 5);
    run_op(5'b01111, 32'd100, 32'd7, 0);
    run_op(5'b00111, 32'h8000_0001, 32'd0, 0);
    run_op(5'b01010, 32'h8000_0000, 32'd31, 1);

    // DIV aborted by clear at acceptance+10, then a normal ADD.
    req_valid = 1'b1; req_op = 5'b01111; req_ra = 32'd1000; req_rb = 32'd3;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (9) @(negedge clock);
    check("abort_busy_before", busy, 1'b1);
    clear = 1'b0; req_valid = 1'b1; res_ready = 1'b1;
    @(negedge clock);
    check("abort_ready", req_ready, 1'b1);
    check("abort_outs", {busy, res_valid, alu_op}, 7'd0);
    @(negedge clock);
    check("rst_prio_ready", req_ready, 1'b1);
    check("rst_prio_busy", busy, 1'b0);
    clear = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check("abort_no_valid", res_valid, 1'b0);
      @(negedge clock);
    end
    run_op(5'b00011, 32'd20, 32'd22, 0);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(19, 33) % 32);
      else op = legal_ops[$urandom_range(0, 15)];
      ra = $urandom;
      rb = $urandom;
      if (op == 5'd15 && $urandom_range(0, 3) == 0) rb = 32'd0;
      run_op(op, ra, rb, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 16, SHALL set the cycle count of a MUL operation (legal range 1..63).
REQ-002 Parameter DIV_CYCLES, default 32, SHALL set the cycle count of a DIV operation (legal range 1..63).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clock  in  1  system clock; all state updates on the rising edge.
REQ-005 clear  in  1  synchronous active-low reset.
REQ-006 req_valid  in  1  requester has an operation pending.
REQ-007 req_ready  out  1  sequencer can accept an operation this cycle.
REQ-008 req_op  in  5  ALU operation code.
REQ-009 req_ra, req_rb  in  32 each  operands A and B.
REQ-010 alu_op  out  5  operation code driven to the ALU.
REQ-011 alu_ra, alu_rb  out  32 each  operands driven to the ALU.
REQ-012 alu_hi, alu_lo  in  32 each  ALU high and low results.
REQ-013 res_valid  out  1  result registers hold a completed result.
REQ-014 res_ready  in  1  consumer accepts the result.
REQ-015 res_hi, res_lo  out  32 each  captured high and low results.
REQ-016 err_div0, err_illegal  out  1 each  error flags, qualified by res_valid.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 Legal opcodes SHALL be ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, ADDI 01100, ANDI 01101, ORI 01110, DIV 01111, MUL 10000, NEG 10001, NOT 10010.
REQ-019 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-020 req_ready SHALL equal 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-021 On acceptance, req_op, req_ra and req_rb SHALL be latched; a legal op moves the FSM to EXEC with the cycle counter loaded to N-1.
REQ-022 N SHALL be MUL_CYCLES for MUL, DIV_CYCLES for DIV, and 1 for every other legal op.
REQ-023 During EXEC, alu_op, alu_ra and alu_rb SHALL be driven from the latched values and held stable; in IDLE and DONE they SHALL be 0.
REQ-024 In EXEC the counter SHALL decrement each cycle; on the edge where it equals 0, alu_hi and alu_lo are captured into res_hi and res_lo, and the FSM moves to DONE.
REQ-025 res_valid SHALL rise exactly N cycles after the acceptance edge.
REQ-026 DIV with latched RB = 0 SHALL skip EXEC and enter DONE on the edge after acceptance, with res_hi = res_lo = 0 and err_div0 = 1.
REQ-027 An illegal opcode SHALL skip EXEC and enter DONE on the edge after acceptance, with res_hi = res_lo = 0 and err_illegal = 1.
REQ-028 In DONE, res_valid SHALL be 1 and res_hi, res_lo, err_div0 and err_illegal SHALL be held until res_ready = 1.
REQ-029 On an edge in DONE with res_ready = 1, the FSM SHALL return to IDLE and clear res_valid and both error flags; res_hi and res_lo keep their values.
REQ-030 The earliest next acceptance after a completed handoff SHALL be the edge following the return to IDLE; back-to-back throughput is one op per N+2 cycles.
REQ-031 req_valid, req_op and operand changes outside IDLE SHALL have no effect.
REQ-032 res_ready asserted outside DONE SHALL have no effect.

Reset
REQ-033 On any edge with clear = 0, the FSM SHALL enter IDLE, the counter SHALL load 0, and all outputs SHALL become 0 except req_ready, which becomes 1.
REQ-034 A reset during EXEC or DONE SHALL discard the in-flight operation, and no res_valid SHALL follow.
REQ-035 Reset SHALL take priority over every simultaneous handshake event.

Verification
REQ-036 ADD with RA = 5, RB = 7, res_ready held at 1 -> res_valid for one cycle at acceptance+1, res_lo = 12, res_hi = 0, req_ready high again at acceptance+2.
REQ-037 MUL with MUL_CYCLES = 16 and a model ALU -> alu_op = 10000 stable for 16 cycles; res_valid at acceptance+16.
REQ-038 DIV with RB = 0 -> res_valid at acceptance+1, err_div0 = 1, res_lo = res_hi = 0, and alu_op never equals 01111.
REQ-039 Opcode 11111 -> err_illegal = 1 at acceptance+1; with res_ready held at 0 for 5 cycles, the outputs are held and req_ready stays 0 until the handoff.
REQ-040 DIV accepted, clear = 0 at acceptance+10 -> IDLE on the next edge, res_valid never asserts, and a following ADD completes normally.
